// File: rtl/inv_mix_columns_seq.sv
// Multi-cycle AES InvMixColumns stage: accepts a 128-bit state, mixes COLS_PER_CYCLE
// columns per clock (or bypasses the mix), then holds the result until downstream takes it.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] State_In,
    input  logic         Bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] State_Out,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_MIX, S_DONE} state_t;

    // The 2-bit counter wraps naturally; a step of 4 truncates to 0.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_col [4];
    logic [1:0]  w_idx [COLS_PER_CYCLE];
    logic [31:0] w_mix [COLS_PER_CYCLE];
    logic        w_last;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiples 9, b, d, e built from the 2x/4x/8x doublings of each byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_idx[k] = r_cnt + 2'(k);
            w_mix[k] = inv_mix_col(r_col[w_idx[k]]);
        end
    end

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = Bypass ? S_DONE : S_MIX;
            S_MIX:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cnt <= 2'd0;
            for (int i = 0; i < 4; i++) r_col[i] <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cnt <= 2'd0;
                        for (int i = 0; i < 4; i++) r_col[i] <= State_In[127-32*i -: 32];
                    end
                end
                S_MIX: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) r_col[w_idx[k]] <= w_mix[k];
                    r_cnt <= r_cnt + STEP;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign State_Out = {r_col[0], r_col[1], r_col[2], r_col[3]};

endmodule
